// File: rtl/qam_symbol_scheduler_pkg.sv
// Shared types for the QAM symbol scheduler: symbol type, scheduler state
// encoding and a saturating counter helper.
package qam_symbol_scheduler_pkg;

  typedef logic [3:0] qam_sym_t;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_PRIME = 2'd1,
    SCHED_RUN   = 2'd2
  } SCHED_STATE;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/qam_symbol_scheduler_symbol_fifo.sv
// Synchronous symbol FIFO with natural-wrap pointers and an explicit level
// counter so that full (level == DEPTH) is distinguishable from empty.
module symbol_fifo
  import qam_symbol_scheduler_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  qam_sym_t                 din_i,
  output qam_sym_t                 head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  qam_sym_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     level_q, level_d;
  logic            push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign head_o  = mem_q[rd_q];
  assign level_o = level_q;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);
  assign overflow_o = push_i && full_o && !pop_ok;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// Paces buffered QAM symbols out at one strobe per ipSymbolPeriod clocks,
// substituting the idle symbol on underrun and counting under/overflows.
module qam_symbol_scheduler
  import qam_symbol_scheduler_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                     ipClk,
  input  logic                     ipReset,
  input  logic                     ipEnable,
  input  logic [15:0]              ipSymbolPeriod,
  input  logic [3:0]               ipIdleSymbol,
  input  logic                     ipClearCounters,
  input  logic [3:0]               ipQAMBlock,
  input  logic                     ipQAMBlockValid,
  output logic                     opReady,
  output logic [3:0]               opQAMBlock,
  output logic                     opQAMBlockValid,
  output logic                     opSymbolIsData,
  output logic [$clog2(DEPTH):0]   opFIFO_Level,
  output logic [15:0]              opUnderruns,
  output logic [15:0]              opOverflows
);

  localparam int LW = $clog2(DEPTH) + 1;

  SCHED_STATE        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  qam_sym_t          sym_q, sym_d;
  logic              vld_q, vld_d;
  logic              isdata_q, isdata_d;
  logic [CNT_W-1:0]  und_q, und_d, ovf_q, ovf_d;

  qam_sym_t          head;
  logic [LW-1:0]     level;
  logic              full, empty, overflow, fire, pop;

  // Emit only while still enabled; dropping enable suppresses that slot.
  assign fire = (state_q == SCHED_RUN) && ipEnable && (cnt_q == '0);
  assign pop  = fire && !empty;

  symbol_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (ipClk),
    .rst_i      (ipReset),
    .push_i     (ipQAMBlockValid),
    .pop_i      (pop),
    .din_i      (ipQAMBlock),
    .head_o     (head),
    .level_o    (level),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sym_d    = sym_q;
    vld_d    = 1'b0;
    isdata_d = isdata_q;
    und_d    = und_q;
    ovf_d    = ovf_q;
    case (state_q)
      SCHED_IDLE: if (ipEnable) state_d = SCHED_PRIME;
      SCHED_PRIME: begin
        if (!ipEnable) state_d = SCHED_IDLE;
        else if (level >= LW'(PRIME_LEVEL)) begin
          state_d = SCHED_RUN;
          cnt_d   = '0;
        end
      end
      SCHED_RUN: begin
        if (!ipEnable) state_d = SCHED_IDLE;
        else if (cnt_q == '0) begin
          vld_d = 1'b1;
          cnt_d = (ipSymbolPeriod == '0) ? '0 : ipSymbolPeriod - 16'd1;
          if (!empty) begin
            sym_d    = head;
            isdata_d = 1'b1;
          end else begin
            sym_d    = ipIdleSymbol;
            isdata_d = 1'b0;
            und_d    = sat_inc(und_q);
          end
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = SCHED_IDLE;
    endcase
    if (overflow) ovf_d = sat_inc(ovf_q);
    if (ipClearCounters) begin
      und_d = '0;
      ovf_d = '0;
    end
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q  <= SCHED_IDLE;
      cnt_q    <= '0;
      sym_q    <= '0;
      vld_q    <= 1'b0;
      isdata_q <= 1'b0;
      und_q    <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sym_q    <= sym_d;
      vld_q    <= vld_d;
      isdata_q <= isdata_d;
      und_q    <= und_d;
      ovf_q    <= ovf_d;
    end
  end

  assign opReady         = !full;
  assign opQAMBlock      = sym_q;
  assign opQAMBlockValid = vld_q;
  assign opSymbolIsData  = isdata_q;
  assign opFIFO_Level    = level;
  assign opUnderruns     = und_q;
  assign opOverflows     = ovf_q;

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Directed bench for qam_symbol_scheduler (DEPTH=16, PRIME_LEVEL=8).
module tb_qam_symbol_scheduler;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0, vin = 1'b0;
  logic [15:0] per = '0;
  logic [3:0]  idle = '0, din = '0;
  logic        rdy, vout, isd;
  logic [3:0]  dout;
  logic [4:0]  lvl;
  logic [15:0] und, ovf;

  int vectors = 0;
  int miscompares = 0;

  qam_symbol_scheduler #(.DEPTH(16), .PRIME_LEVEL(8)) dut (
    .ipClk           (clk),
    .ipReset         (rst),
    .ipEnable        (en),
    .ipSymbolPeriod  (per),
    .ipIdleSymbol    (idle),
    .ipClearCounters (clr),
    .ipQAMBlock      (din),
    .ipQAMBlockValid (vin),
    .opReady         (rdy),
    .opQAMBlock      (dout),
    .opQAMBlockValid (vout),
    .opSymbolIsData  (isd),
    .opFIFO_Level    (lvl),
    .opUnderruns     (und),
    .opOverflows     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from now until the next visible strobe, bounded.
  task automatic wait_strobe(input string tag, input int gap);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (vout !== 1'b1 && n < 40);
    chk(tag, n, gap);
  endtask

  function automatic logic [3:0] d(input int j);
    return 4'(j) ^ 4'hA;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"}, vout, 0);
    chk({tag, "_sym"}, dout, 0);
    chk({tag, "_isd"}, isd, 0);
    chk({tag, "_lvl"}, lvl, 0);
    chk({tag, "_und"}, und, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_rdy"}, rdy, 1);
  endtask

  initial begin
    repeat (2) tick();
    chk_reset("reset");
    rst = 1'b0;

    // Priming: push 0..7 with P=4
    en = 1'b1; per = 16'd4; idle = 4'hA;
    for (int i = 0; i < 8; i++) begin
      vin = 1'b1; din = 4'(i); tick();
    end
    chk("prime_lvl", lvl, 8);
    vin = 1'b0;
    wait_strobe("t1_first_gap", 2);
    chk("t1_sym0", dout, 0);
    chk("t1_isd0", isd, 1);
    chk("t1_lvl_after_pop", lvl, 7);
    for (int i = 1; i < 8; i++) begin
      wait_strobe("t1_gap", 4);
      chk("t1_sym", dout, 4'(i));
      chk("t1_isd", isd, 1);
    end

    // Underrun: idle symbol 0xA
    for (int k = 1; k <= 3; k++) begin
      wait_strobe("t2_gap", 4);
      chk("t2_sym", dout, 4'hA);
      chk("t2_isd", isd, 0);
      chk("t2_und", und, 16'(k));
    end
    chk("t2_lvl", lvl, 0);

    // Period change mid-symbol: current gap stays 4
    tick();
    per = 16'd2;
    wait_strobe("t5_gap_cur", 3);
    wait_strobe("t5_gap_new", 2);
    wait_strobe("t5_gap_new2", 2);
    chk("t5_und", und, 6);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_stopped", vout, 0);
    end

    // Overflow: 20 pushes into 16 entries
    for (int i = 0; i < 20; i++) begin
      vin = 1'b1; din = 4'(i); tick();
      if (i == 14) chk("t3_rdy_15", rdy, 1);
      if (i == 15) begin
        chk("t3_rdy_16", rdy, 0);
        chk("t3_lvl_16", lvl, 16);
      end
      if (i == 16) chk("t3_ovf_1", ovf, 1);
    end
    vin = 1'b0;
    chk("t3_ovf_4", ovf, 4);
    chk("t3_und_held", und, 6);
    clr = 1'b1; vin = 1'b1; din = 4'hF;
    tick();
    chk("t3_clr_prio_ovf", ovf, 0);
    chk("t3_clr_und", und, 0);
    clr = 1'b0; vin = 1'b0;
    tick();
    chk("t3_ovf_after", ovf, 0);
    chk("t3_lvl_after", lvl, 16);
    chk("t3_rdy_after", rdy, 0);

    // Full FIFO, P=0, push every cycle
    per = 16'd0; en = 1'b1;
    tick(); tick();
    for (int j = 0; j < 20; j++) begin
      vin = 1'b1; din = d(j); tick();
      chk("t4_vld", vout, 1);
      chk("t4_lvl", lvl, 16);
      chk("t4_sym", dout, (j < 16) ? 4'(j) : d(j - 16));
    end
    vin = 1'b0; en = 1'b0;
    tick();
    chk("t4_stop_vld", vout, 0);
    chk("t4_stop_lvl", lvl, 16);
    chk("t4_ovf", ovf, 0);

    // Drain to 5 queued at P=1, then disable
    per = 16'd1; en = 1'b1;
    repeat (13) tick();
    chk("t6_lvl5", lvl, 5);
    chk("t6_vld", vout, 1);
    chk("t6_sym", dout, d(14));
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t6_off_vld", vout, 0);
      chk("t6_off_lvl", lvl, 5);
    end

    // Re-enable: top up to PRIME_LEVEL, resume in order at P=3
    per = 16'd3; en = 1'b1;
    for (int x = 1; x <= 3; x++) begin
      vin = 1'b1; din = 4'(x); tick();
    end
    vin = 1'b0;
    wait_strobe("t6_resume_gap", 2);
    chk("t6_resume_sym", dout, d(15));
    wait_strobe("t6_gap", 3);
    chk("t6_sym16", dout, d(16));
    wait_strobe("t6_gap", 3);
    chk("t6_sym17", dout, d(17));
    chk("t6_lvl_run", lvl, 5);

    // Asynchronous reset mid-RUN
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_vld", vout, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qam_symbol_scheduler.md
# qam_symbol_scheduler

Paces 4-bit QAM symbols from the UART streamer into the QAM modulator at a register-programmed symbol rate. Incoming symbols are buffered in a small FIFO and released as one-cycle strobes at exactly one symbol per `ipSymbolPeriod` clocks. On underrun the block inserts a programmable idle symbol, and it counts underruns and overflows for the register file. It sits between the streamer's QAM block output and the QAM modulator input, and is configured and monitored through the register bank.

## Interface

**Parameters**
- `DEPTH`, 16: FIFO depth in symbols; power of two, minimum 4.
- `PRIME_LEVEL`, 8: FIFO level required before symbol output starts; 1..`DEPTH`.

**Ports**
- `ipClk` in 1: the single clock.
- `ipReset` in 1: asynchronous, active-high reset.
- `ipEnable` in 1: run request, level-sensitive.
- `ipSymbolPeriod` in 16: clocks per symbol; 0 is treated as 1.
- `ipIdleSymbol` in 4: symbol emitted on underrun.
- `ipClearCounters` in 1: single-cycle clear of both error counters.
- `ipQAMBlock` in 4: input symbol.
- `ipQAMBlockValid` in 1: push strobe for `ipQAMBlock`.
- `opReady` out 1: FIFO can accept a symbol this cycle.
- `opQAMBlock` out 4: current symbol; held between strobes.
- `opQAMBlockValid` out 1: one-cycle strobe per emitted symbol.
- `opSymbolIsData` out 1: last emitted symbol came from the FIFO (0 means it was the idle symbol).
- `opFIFO_Level` out clog2(DEPTH)+1: current FIFO occupancy.
- `opUnderruns` out 16: saturating underrun count.
- `opOverflows` out 16: saturating overflow count.

## Operation

**States**
- IDLE
  - No strobes are emitted. The FIFO still accepts pushes.
  - `ipEnable`=1 → PRIME.
- PRIME
  - Wait until `opFIFO_Level` ≥ `PRIME_LEVEL`, then → RUN with the period counter loaded to 0.
  - `ipEnable`=0 → IDLE.
- RUN
  - The period counter decrements each cycle.
  - When the counter is 0:
    - Emit a strobe.
    - Reload the counter with max(`ipSymbolPeriod`,1)−1.
    - If the FIFO is non-empty: pop the head into `opQAMBlock` and set `opSymbolIsData`=1.
    - If the FIFO is empty: load `ipIdleSymbol`, set `opSymbolIsData`=0, and increment `opUnderruns`.
  - `ipEnable`=0 → IDLE immediately. No strobe is emitted that cycle, and FIFO contents are kept.

**FIFO**
- Push is accepted when `ipQAMBlockValid`=1 and (level < `DEPTH`, or a pop occurs in the same cycle).
- A push while full with no pop is dropped and increments `opOverflows`.
- `opReady` = (level < `DEPTH`); it does not anticipate a same-cycle pop.
- Simultaneous push and pop leave the level unchanged. An empty FIFO never bypasses a same-cycle push to the output.
- Read and write pointers are clog2(DEPTH) bits and wrap naturally.

**Counters**
- Both counters saturate at 0xFFFF.
- `ipClearCounters` zeroes both counters and takes priority over any same-cycle increment.
- `ipSymbolPeriod` is sampled only at reload. A change takes effect after the current symbol completes.

## Timing

**Reset values** (all outputs):
- State IDLE.
- `opQAMBlock`=0, `opQAMBlockValid`=0, `opSymbolIsData`=0.
- `opFIFO_Level`=0, `opUnderruns`=0, `opOverflows`=0.
- `opReady`=1.
- Pointers and counter at 0.

**Latencies**
- `opFIFO_Level` updates the cycle after the push or pop.
- PRIME → RUN transition: the first strobe occurs on the first RUN cycle, registered, i.e. 1 cycle after the level condition is seen.
- In steady RUN, strobes are spaced exactly max(P,1) cycles apart. P=1 gives a strobe every cycle.
- All outputs are registered.

**Reset mid-operation**
- Asserting `ipReset` takes effect asynchronously.
- It empties the FIFO, zeroes both counters, and returns the block to IDLE.

## Structure

**Shared package**
- Add a `SCHED_STATE` enum (IDLE, PRIME, RUN) to `Structures`.
- Add the 4-bit QAM symbol type to `Structures` if it is not already present.

**Integration**
- `ipSymbolPeriod`, `ipIdleSymbol` and `ipEnable` come from the write registers.
- Level, underruns and overflows go to the read registers.

**Sub-module**
- One sub-module, `symbol_fifo`: a parameterised synchronous FIFO with push, pop, level and full/empty.
- The scheduler FSM and counters stay in the top module.

## Test plan

1. **Priming:** reset, `PRIME_LEVEL`=8, P=4, enable, push 8 symbols 0..7 → strobes start 1 cycle after level reaches 8; symbols 0..7 emitted in order, exactly 4 cycles apart; `opSymbolIsData`=1.
2. **Underrun:** continue test 1 with no further pushes and `ipIdleSymbol`=0xA → after symbol 7, strobes carry 0xA with `opSymbolIsData`=0; `opUnderruns` increments once per strobe.
3. **Overflow:** enable=0, push 20 symbols into the `DEPTH`=16 FIFO → `opReady`=0 after the 16th push; level=16; `opOverflows`=4. Then pulse `ipClearCounters` → `opOverflows`=0.
4. **Full FIFO with P=0:** FIFO full, RUN with P=0, push every cycle → a strobe every cycle; level stays 16; no overflows counted.
5. **Period change:** P changes from 4 to 2 mid-symbol → the current gap remains 4 cycles; subsequent gaps are 2.
6. **Disable and reset:**
   - Drop `ipEnable` in RUN with 5 symbols queued → strobes stop the next cycle and level stays 5.
   - Re-enable → symbols resume in order once the `PRIME_LEVEL` condition is met.
   - Assert `ipReset` mid-RUN → all outputs return to their reset values asynchronously.
